// File: rtl/sweep_acq_controller.sv
// Sweep-acquisition sequencer: steps a MICROROC DAC code from StartDac to EndDac, reloading slow
// control, acquiring MaxWordNumber words and emitting a framed record per step.
module sweep_acq_controller #(
  parameter int          SC_LOAD_WAIT = 2000,
  parameter int          DRAIN_CYCLES = 256,
  parameter logic [15:0] STEP_HEADER  = 16'h5A5A,
  parameter logic [15:0] SWEEP_END    = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        SweepAcqStartStop,
  input  logic [9:0]  StartDac,
  input  logic [9:0]  EndDac,
  input  logic [9:0]  DacStep,
  input  logic [15:0] MaxWordNumber,
  input  logic [15:0] ParallelData,
  input  logic        ParallelData_en,
  output logic [9:0]  SweepAcq10BitDac,
  output logic        SweepAcqMicrorocSCParameterLoad,
  output logic        SweepAcqMicrorocAcqStartStop,
  output logic [15:0] SweepAcqData,
  output logic        SweepAcqData_en,
  output logic        SweepDone
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] HDR       = 4'd1;
  localparam logic [3:0] DACW      = 4'd2;
  localparam logic [3:0] LOAD      = 4'd3;
  localparam logic [3:0] WAIT_LOAD = 4'd4;
  localparam logic [3:0] ACQ       = 4'd5;
  localparam logic [3:0] DRAIN     = 4'd6;
  localparam logic [3:0] TAIL      = 4'd7;
  localparam logic [3:0] NEXT      = 4'd8;
  localparam logic [3:0] ENDW      = 4'd9;
  localparam logic [3:0] DONE      = 4'd10;

  localparam logic [15:0] WAIT_LAST  = 16'(SC_LOAD_WAIT - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  logic [3:0]  state;
  logic        startPrev;
  logic [9:0]  dac;
  logic [9:0]  endLat;
  logic [9:0]  stepLat;
  logic [15:0] maxLat;
  logic [15:0] wordCount;
  logic [15:0] timer;
  logic [15:0] dataReg;
  logic        dataEnReg;
  logic        scLoadReg;
  logic        acqEnReg;
  logic        doneReg;

  logic [10:0] nextSum;
  logic [15:0] countInc;

  // The 11-bit sum keeps the carry so a step past code 1023 ends the sweep instead of wrapping.
  assign nextSum  = {1'b0, dac} + {1'b0, stepLat};
  assign countInc = (wordCount == 16'hFFFF) ? wordCount : wordCount + 16'd1;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      startPrev <= 1'b0;
      dac       <= 10'd0;
      endLat    <= 10'd0;
      stepLat   <= 10'd1;
      maxLat    <= 16'd0;
      wordCount <= 16'd0;
      timer     <= 16'd0;
      dataReg   <= 16'd0;
      dataEnReg <= 1'b0;
      scLoadReg <= 1'b0;
      acqEnReg  <= 1'b0;
      doneReg   <= 1'b0;
    end else begin
      startPrev <= SweepAcqStartStop;
      dataEnReg <= 1'b0;
      scLoadReg <= 1'b0;
      // Dropping the run level aborts a sweep in progress without writing tail or end words.
      if (!SweepAcqStartStop && state != IDLE && state != DONE) begin
        state    <= IDLE;
        acqEnReg <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (SweepAcqStartStop && !startPrev) begin
              endLat    <= EndDac;
              stepLat   <= (DacStep == 10'd0) ? 10'd1 : DacStep;
              maxLat    <= MaxWordNumber;
              dac       <= StartDac;
              doneReg   <= 1'b0;
              wordCount <= 16'd0;
              timer     <= 16'd0;
              state     <= (StartDac > EndDac) ? ENDW : HDR;
            end
          end
          HDR: begin
            dataReg   <= STEP_HEADER;
            dataEnReg <= 1'b1;
            state     <= DACW;
          end
          DACW: begin
            dataReg   <= {6'b0, dac};
            dataEnReg <= 1'b1;
            state     <= LOAD;
          end
          LOAD: begin
            scLoadReg <= 1'b1;
            timer     <= 16'd0;
            state     <= WAIT_LOAD;
          end
          WAIT_LOAD: begin
            if (timer == WAIT_LAST) begin
              timer <= 16'd0;
              if (maxLat == 16'd0) begin
                state <= TAIL;
              end else begin
                state    <= ACQ;
                acqEnReg <= 1'b1;
              end
            end else begin
              timer <= timer + 16'd1;
            end
          end
          ACQ: begin
            if (ParallelData_en) begin
              dataReg   <= ParallelData;
              dataEnReg <= 1'b1;
              wordCount <= countInc;
              if (countInc == maxLat) begin
                acqEnReg <= 1'b0;
                timer    <= 16'd0;
                state    <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (ParallelData_en) begin
              dataReg   <= ParallelData;
              dataEnReg <= 1'b1;
            end
            if (timer == DRAIN_LAST) begin
              timer <= 16'd0;
              state <= TAIL;
            end else begin
              timer <= timer + 16'd1;
            end
          end
          TAIL: begin
            dataReg   <= wordCount;
            dataEnReg <= 1'b1;
            state     <= NEXT;
          end
          NEXT: begin
            if (nextSum > {1'b0, endLat}) begin
              state <= ENDW;
            end else begin
              dac       <= nextSum[9:0];
              wordCount <= 16'd0;
              state     <= HDR;
            end
          end
          ENDW: begin
            dataReg   <= SWEEP_END;
            dataEnReg <= 1'b1;
            doneReg   <= 1'b1;
            state     <= DONE;
          end
          DONE: begin
            if (!SweepAcqStartStop) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign SweepAcq10BitDac                = dac;
  assign SweepAcqMicrorocSCParameterLoad = scLoadReg;
  assign SweepAcqMicrorocAcqStartStop    = acqEnReg;
  assign SweepAcqData                    = dataReg;
  assign SweepAcqData_en                 = dataEnReg;
  assign SweepDone                       = doneReg;

endmodule

// File: tb/tb_sweep_acq_controller.sv
// Self-checking bench for sweep_acq_controller: table of full sweeps checked against a frame
// model, plus hand sequences for abort and drain-window corner cases.
module tb_sweep_acq_controller;

  typedef struct {
    logic [9:0]  startDac;
    logic [9:0]  endDac;
    logic [9:0]  dacStep;
    logic [15:0] maxWords;
    int          expWords;
    int          expLoads;
    logic        expAcq;
  } sweepVec_t;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SweepAcqStartStop = 1'b0;
  logic [9:0]  StartDac = 10'd0;
  logic [9:0]  EndDac = 10'd0;
  logic [9:0]  DacStep = 10'd0;
  logic [15:0] MaxWordNumber = 16'd0;
  logic [15:0] ParallelData = 16'd0;
  logic        ParallelData_en = 1'b0;
  logic [9:0]  SweepAcq10BitDac;
  logic        SweepAcqMicrorocSCParameterLoad;
  logic        SweepAcqMicrorocAcqStartStop;
  logic [15:0] SweepAcqData;
  logic        SweepAcqData_en;
  logic        SweepDone;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] gotWords[$];
  logic [15:0] expWords[$];
  int          scLoads = 0;
  logic        acqSeen = 1'b0;
  logic        feedEnable = 1'b0;
  int          feedIdx = 0;
  sweepVec_t   vecs[5];

  sweep_acq_controller dut (
    .Clk                             (Clk),
    .reset_n                         (reset_n),
    .SweepAcqStartStop               (SweepAcqStartStop),
    .StartDac                        (StartDac),
    .EndDac                          (EndDac),
    .DacStep                         (DacStep),
    .MaxWordNumber                   (MaxWordNumber),
    .ParallelData                    (ParallelData),
    .ParallelData_en                 (ParallelData_en),
    .SweepAcq10BitDac                (SweepAcq10BitDac),
    .SweepAcqMicrorocSCParameterLoad (SweepAcqMicrorocSCParameterLoad),
    .SweepAcqMicrorocAcqStartStop    (SweepAcqMicrorocAcqStartStop),
    .SweepAcqData                    (SweepAcqData),
    .SweepAcqData_en                 (SweepAcqData_en),
    .SweepDone                       (SweepDone)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (reset_n) begin
      if (SweepAcqData_en) gotWords.push_back(SweepAcqData);
      if (SweepAcqMicrorocSCParameterLoad) scLoads++;
      if (SweepAcqMicrorocAcqStartStop) acqSeen = 1'b1;
    end
  end

  // Auto-feeder: one word every other cycle while acquisition is enabled, numbered D000+n.
  always @(negedge Clk) begin
    if (feedEnable) begin
      if (!ParallelData_en && SweepAcqMicrorocAcqStartStop) begin
        ParallelData    = 16'hD000 + 16'(feedIdx);
        ParallelData_en = 1'b1;
        feedIdx++;
      end else begin
        ParallelData_en = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic clearMonitor();
    gotWords.delete();
    scLoads = 0;
    acqSeen = 1'b0;
    feedIdx = 0;
  endtask

  task automatic buildExpected(input sweepVec_t v);
    int stepEff = (v.dacStep == 10'd0) ? 1 : int'(v.dacStep);
    int n = 0;
    expWords.delete();
    if (v.startDac <= v.endDac) begin
      for (int d = int'(v.startDac); d <= int'(v.endDac); d += stepEff) begin
        expWords.push_back(16'h5A5A);
        expWords.push_back(16'(d));
        for (int k = 0; k < int'(v.maxWords); k++) begin
          expWords.push_back(16'hD000 + 16'(n));
          n++;
        end
        expWords.push_back(v.maxWords);
      end
    end
    expWords.push_back(16'hFFFF);
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 20000 && !SweepDone; i++) @(negedge Clk);
    checkOutput(name, 32'(SweepDone), 32'd1);
  endtask

  task automatic compareFrame(input string name);
    checkOutput({name, "_len"}, gotWords.size(), expWords.size());
    for (int i = 0; i < gotWords.size() && i < expWords.size(); i++)
      checkOutput($sformatf("%s_word%0d", name, i), 32'(gotWords[i]), 32'(expWords[i]));
  endtask

  task automatic applyStimulus(input sweepVec_t v);
    SweepAcqStartStop = 1'b0;
    repeat (3) @(negedge Clk);
    clearMonitor();
    StartDac          = v.startDac;
    EndDac            = v.endDac;
    DacStep           = v.dacStep;
    MaxWordNumber     = v.maxWords;
    SweepAcqStartStop = 1'b1;
    repeat (2) @(negedge Clk);
    // Scramble parameter inputs: the sweep must run on the values captured at start.
    StartDac      = 10'd0;
    EndDac        = 10'h3FF;
    DacStep       = 10'd5;
    MaxWordNumber = 16'd7;
  endtask

  task automatic runVector(input string name, input sweepVec_t v);
    feedEnable = 1'b1;
    buildExpected(v);
    applyStimulus(v);
    waitDone({name, "_done"});
    repeat (2) @(negedge Clk);
    checkOutput({name, "_frameLen"}, gotWords.size(), v.expWords);
    compareFrame(name);
    checkOutput({name, "_scLoads"}, scLoads, v.expLoads);
    checkOutput({name, "_acqSeen"}, 32'(acqSeen), 32'(v.expAcq));
    SweepAcqStartStop = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput({name, "_doneHolds"}, 32'(SweepDone), 32'd1);
  endtask

  initial begin
    vecs[0] = '{10'd100,  10'd102,  10'd1, 16'd4, 22, 3, 1'b1};
    vecs[1] = '{10'd1020, 10'd1023, 10'd8, 16'd1, 5,  1, 1'b1};
    vecs[2] = '{10'd200,  10'd100,  10'd1, 16'd4, 1,  0, 1'b0};
    vecs[3] = '{10'd50,   10'd50,   10'd1, 16'd0, 4,  1, 1'b0};
    vecs[4] = '{10'd10,   10'd11,   10'd0, 16'd2, 11, 2, 1'b1};

    repeat (2) @(negedge Clk);
    checkOutput("rst_dac",    32'(SweepAcq10BitDac), 32'd0);
    checkOutput("rst_scLoad", 32'(SweepAcqMicrorocSCParameterLoad), 32'd0);
    checkOutput("rst_acq",    32'(SweepAcqMicrorocAcqStartStop), 32'd0);
    checkOutput("rst_data",   32'(SweepAcqData), 32'd0);
    checkOutput("rst_dataEn", 32'(SweepAcqData_en), 32'd0);
    checkOutput("rst_done",   32'(SweepDone), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 5; i++) runVector($sformatf("vec%0d", i), vecs[i]);

    // Abort mid-acquisition after two of four words.
    begin
      sweepVec_t restartVec;
      logic [15:0] abortExp[4];
      abortExp = '{16'h5A5A, 16'h012C, 16'hE001, 16'hE002};
      feedEnable = 1'b0;
      ParallelData_en = 1'b0;
      SweepAcqStartStop = 1'b0;
      repeat (3) @(negedge Clk);
      clearMonitor();
      StartDac = 10'd300; EndDac = 10'd305; DacStep = 10'd1; MaxWordNumber = 16'd4;
      SweepAcqStartStop = 1'b1;
      for (int i = 0; i < 5000 && !SweepAcqMicrorocAcqStartStop; i++) @(negedge Clk);
      checkOutput("abort_acqRise", 32'(SweepAcqMicrorocAcqStartStop), 32'd1);
      ParallelData = 16'hE001; ParallelData_en = 1'b1;
      @(negedge Clk);
      ParallelData = 16'hE002;
      @(negedge Clk);
      ParallelData_en = 1'b0;
      SweepAcqStartStop = 1'b0;
      @(negedge Clk);
      checkOutput("abort_acqLow", 32'(SweepAcqMicrorocAcqStartStop), 32'd0);
      repeat (300) @(negedge Clk);
      checkOutput("abort_len", gotWords.size(), 32'd4);
      for (int i = 0; i < gotWords.size() && i < 4; i++)
        checkOutput($sformatf("abort_word%0d", i), 32'(gotWords[i]), 32'(abortExp[i]));
      checkOutput("abort_done", 32'(SweepDone), 32'd0);
      checkOutput("abort_scLoads", scLoads, 32'd1);
      restartVec = '{10'd300, 10'd300, 10'd1, 16'd2, 6, 1, 1'b1};
      runVector("restart", restartVec);
    end

    // Last counted word followed by three late words inside the drain window.
    begin
      logic [15:0] drainExp[10];
      drainExp = '{16'h5A5A, 16'h0190, 16'hF000, 16'hF001, 16'hF002,
                   16'hF003, 16'hF004, 16'hF005, 16'h0003, 16'hFFFF};
      feedEnable = 1'b0;
      ParallelData_en = 1'b0;
      SweepAcqStartStop = 1'b0;
      repeat (3) @(negedge Clk);
      clearMonitor();
      StartDac = 10'd400; EndDac = 10'd400; DacStep = 10'd1; MaxWordNumber = 16'd3;
      SweepAcqStartStop = 1'b1;
      repeat (10) @(negedge Clk);
      ParallelData = 16'hBAD0; ParallelData_en = 1'b1;
      @(negedge Clk);
      ParallelData_en = 1'b0;
      for (int i = 0; i < 5000 && !SweepAcqMicrorocAcqStartStop; i++) @(negedge Clk);
      checkOutput("drain_acqRise", 32'(SweepAcqMicrorocAcqStartStop), 32'd1);
      for (int k = 0; k < 6; k++) begin
        if (k == 3) checkOutput("drain_acqLow", 32'(SweepAcqMicrorocAcqStartStop), 32'd0);
        ParallelData = 16'hF000 + 16'(k);
        ParallelData_en = 1'b1;
        @(negedge Clk);
      end
      ParallelData_en = 1'b0;
      waitDone("drain_done");
      repeat (2) @(negedge Clk);
      checkOutput("drain_len", gotWords.size(), 32'd10);
      for (int i = 0; i < gotWords.size() && i < 10; i++)
        checkOutput($sformatf("drain_word%0d", i), 32'(gotWords[i]), 32'(drainExp[i]));
      SweepAcqStartStop = 1'b0;
      repeat (3) @(negedge Clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
